// File: rtl/vram_pkg.sv
// Shared constants and types for the character VRAM arbiter.
package vram_pkg;

  localparam int VRAM_AW = 11;
  localparam int VRAM_DW = 8;

  localparam int REQ_CLEAR  = 0;
  localparam int REQ_SCROLL = 1;
  localparam int REQ_CHAR   = 2;

  typedef enum logic {
    ST_IDLE,
    ST_OWNED
  } arb_state_e;

endpackage

// File: rtl/arb_pick.sv
// Combinational requester picker: one-hot winner plus valid.
// VRAM_ARB_RR_EN selects round-robin from ptr_i; otherwise lowest index wins.
module arb_pick
  import vram_pkg::*;
#(
  parameter int NREQ = 3,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IW-1:0]   ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic            valid_o
);

`ifdef VRAM_ARB_RR_EN
  logic [IW-1:0] idx;

  always_comb begin
    gnt_o   = '0;
    valid_o = 1'b0;
    idx     = '0;
    for (int i = 0; i < NREQ; i++) begin
      idx = IW'((int'(ptr_i) + i) % NREQ);
      if (!valid_o && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        valid_o    = 1'b1;
      end
    end
  end
`else
  logic unused_ptr;
  assign unused_ptr = ^ptr_i;

  always_comb begin
    gnt_o   = '0;
    valid_o = 1'b0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        gnt_o    = '0;
        gnt_o[i] = 1'b1;
        valid_o  = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/vram_arbiter.sv
// Grants the single-port character VRAM to one requester per burst and tags read returns.
// Picker mode is chosen by VRAM_ARB_RR_EN (round-robin when defined, fixed priority otherwise).
module vram_arbiter
  import vram_pkg::*;
#(
  parameter int NREQ      = 3,
  parameter int AW        = VRAM_AW,
  parameter int DW        = VRAM_DW,
  parameter int MAX_BURST = 64,
  parameter int RD_LAT    = 1
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [NREQ-1:0]    i_req,
  input  logic [NREQ*AW-1:0] i_addr,
  input  logic [NREQ-1:0]    i_we,
  input  logic [NREQ*DW-1:0] i_din,
  output logic [NREQ-1:0]    o_gnt,
  output logic [AW-1:0]      o_vram_addr,
  output logic               o_vram_w,
  output logic               o_vram_ce,
  output logic [DW-1:0]      o_vram_din,
  input  logic [DW-1:0]      i_vram_dout,
  output logic [NREQ-1:0]    o_rvalid,
  output logic [DW-1:0]      o_rdata
);

  localparam int IW = $clog2(NREQ);
  localparam int BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [BW-1:0] BURST_LAST = BW'((MAX_BURST > 0) ? MAX_BURST - 1 : 0);

  arb_state_e      state_q, state_d;
  logic [IW-1:0]   owner_q, owner_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [BW-1:0]   burst_q, burst_d;

  logic [NREQ-1:0] pick_req, pick_gnt;
  logic            pick_valid;
  logic [IW-1:0]   pick_idx;
  logic            access, rd_access, expire, take_grant;

  logic [RD_LAT-1:0] rd_v_q;
  logic [IW-1:0]     rd_idx_q [RD_LAT];

  assign access    = |(gnt_q & i_req);
  assign rd_access = |(gnt_q & i_req & ~i_we);
  assign expire    = (MAX_BURST != 0) && (burst_q == BURST_LAST);
  // While owned, the owner never competes against itself for the next grant.
  assign pick_req  = (state_q == ST_IDLE) ? i_req : (i_req & ~gnt_q);

  arb_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
    .req_i   (pick_req),
    .ptr_i   (ptr_q),
    .gnt_o   (pick_gnt),
    .valid_o (pick_valid)
  );

  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick_gnt[i]) pick_idx = IW'(i);
    end
  end

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    ptr_d      = ptr_q;
    gnt_d      = gnt_q;
    burst_d    = burst_q;
    take_grant = 1'b0;
    if (state_q == ST_IDLE) begin
      take_grant = pick_valid;
    end else if (!access) begin
      if (pick_valid) begin
        take_grant = 1'b1;
      end else begin
        state_d = ST_IDLE;
        gnt_d   = '0;
        burst_d = '0;
      end
    end else if (expire) begin
      if (pick_valid) take_grant = 1'b1;
      else            burst_d    = '0;
    end else begin
      burst_d = burst_q + 1'b1;
    end
    if (take_grant) begin
      state_d = ST_OWNED;
      owner_d = pick_idx;
      gnt_d   = pick_gnt;
      burst_d = '0;
      ptr_d   = (pick_idx == IW'(NREQ - 1)) ? '0 : pick_idx + 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      owner_q <= '0;
      ptr_q   <= '0;
      gnt_q   <= '0;
      burst_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      burst_q <= burst_d;
    end
  end

  // Read tags travel with the access, so later grant changes cannot misroute them.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rd_v_q <= '0;
      for (int i = 0; i < RD_LAT; i++) rd_idx_q[i] <= '0;
    end else begin
      rd_v_q[0]   <= rd_access;
      rd_idx_q[0] <= owner_q;
      for (int i = 1; i < RD_LAT; i++) begin
        rd_v_q[i]   <= rd_v_q[i-1];
        rd_idx_q[i] <= rd_idx_q[i-1];
      end
    end
  end

  always_comb begin
    o_vram_addr = '0;
    o_vram_din  = '0;
    o_vram_w    = 1'b0;
    o_vram_ce   = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (gnt_q[k] && i_req[k]) begin
        o_vram_addr = i_addr[k*AW +: AW];
        o_vram_din  = i_din[k*DW +: DW];
        o_vram_w    = i_we[k];
        o_vram_ce   = 1'b1;
      end
    end
  end

  always_comb begin
    o_rvalid = '0;
    if (rd_v_q[RD_LAT-1]) o_rvalid[rd_idx_q[RD_LAT-1]] = 1'b1;
  end

  assign o_gnt   = gnt_q;
  assign o_rdata = i_vram_dout;

endmodule

// File: tb/tb_vram_arbiter.sv
// Self-checking bench for vram_arbiter: directed scenarios plus random traffic
// compared each cycle against a queue-based behavioural model.
module tb_vram_arbiter;
  import vram_pkg::*;

  localparam int NREQ      = 3;
  localparam int AW        = 11;
  localparam int DW        = 8;
  localparam int MAX_BURST = 4;
  localparam int RD_LAT    = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [NREQ-1:0] req = '0;
  logic [NREQ-1:0] we = '0;
  logic [AW-1:0]   addr [NREQ];
  logic [DW-1:0]   din  [NREQ];
  logic [DW-1:0]   dout = '0;
  logic [NREQ*AW-1:0] addr_flat;
  logic [NREQ*DW-1:0] din_flat;

  logic [NREQ-1:0] o_gnt, o_rvalid;
  logic [AW-1:0]   o_vram_addr;
  logic            o_vram_w, o_vram_ce;
  logic [DW-1:0]   o_vram_din, o_rdata;

  always #5 clk = ~clk;

  always_comb begin
    addr_flat = '0;
    din_flat  = '0;
    for (int k = 0; k < NREQ; k++) begin
      addr_flat[k*AW +: AW] = addr[k];
      din_flat[k*DW +: DW]  = din[k];
    end
  end

  vram_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .MAX_BURST(MAX_BURST), .RD_LAT(RD_LAT)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_req       (req),
    .i_addr      (addr_flat),
    .i_we        (we),
    .i_din       (din_flat),
    .o_gnt       (o_gnt),
    .o_vram_addr (o_vram_addr),
    .o_vram_w    (o_vram_w),
    .o_vram_ce   (o_vram_ce),
    .o_vram_din  (o_vram_din),
    .i_vram_dout (dout),
    .o_rvalid    (o_rvalid),
    .o_rdata     (o_rdata)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Behavioural model: owner index (-1 = none), accesses in grant, RR start, read-tag queue.
  int m_owner, m_cnt, m_ptr;
  int m_pipe[$];

  function automatic int pick(input logic [NREQ-1:0] r, input int start);
    for (int i = 0; i < NREQ; i++) begin
      if (r[(start + i) % NREQ]) return (start + i) % NREQ;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_cnt   = 0;
    m_ptr   = 0;
    m_pipe.delete();
    for (int i = 0; i < RD_LAT; i++) m_pipe.push_back(-1);
  endtask

  task automatic model_grant(input int w);
    m_owner = w;
    m_cnt   = 0;
    m_ptr   = (w + 1) % NREQ;
  endtask

  task automatic model_step();
    int start, w;
    bit acc;
    logic [NREQ-1:0] others;
    acc = (m_owner >= 0) && req[m_owner];
    void'(m_pipe.pop_front());
    m_pipe.push_back((acc && !we[m_owner]) ? m_owner : -1);
`ifdef VRAM_ARB_RR_EN
    start = m_ptr;
`else
    start = 0;
`endif
    if (m_owner < 0) begin
      w = pick(req, start);
      if (w >= 0) model_grant(w);
    end else begin
      others = req;
      others[m_owner] = 1'b0;
      w = pick(others, start);
      if (!acc) begin
        if (w >= 0) model_grant(w);
        else m_owner = -1;
      end else begin
        m_cnt++;
        if (MAX_BURST != 0 && m_cnt == MAX_BURST) begin
          if (w >= 0) model_grant(w);
          else m_cnt = 0;
        end
      end
    end
  endtask

  logic [NREQ-1:0] s_gnt, s_rv;
  logic            s_ce, s_w;
  logic [AW-1:0]   s_addr;
  logic [DW-1:0]   s_din, s_rd;

  // Called between negedge and posedge with inputs already driven; returns after the next negedge.
  task automatic cycle();
    logic [NREQ-1:0] e_gnt, e_rv;
    bit acc;
    #1;
    s_gnt = o_gnt; s_rv = o_rvalid; s_ce = o_vram_ce; s_w = o_vram_w;
    s_addr = o_vram_addr; s_din = o_vram_din; s_rd = o_rdata;
    e_gnt = '0;
    e_rv  = '0;
    acc   = (m_owner >= 0) && req[m_owner];
    if (m_owner >= 0) e_gnt[m_owner] = 1'b1;
    if (m_pipe[0] >= 0) e_rv[m_pipe[0]] = 1'b1;
    chk_eq("gnt", s_gnt, e_gnt);
    chk_eq("ce", s_ce, acc);
    chk_eq("w", s_w, acc ? we[m_owner] : 1'b0);
    chk_eq("addr", s_addr, acc ? addr[m_owner] : '0);
    chk_eq("din", s_din, acc ? din[m_owner] : '0);
    chk_eq("rvalid", s_rv, e_rv);
    if (m_pipe[0] >= 0) chk_eq("rdata", s_rd, dout);
    model_step();
    @(negedge clk);
  endtask

  // Asynchronous reset asserted mid-cycle, released on a later negedge.
  task automatic reset_async();
    #2;
    rst_n = 1'b0;
    #1;
    chk_eq("rst_gnt", o_gnt, '0);
    chk_eq("rst_ce_w", {o_vram_ce, o_vram_w}, 2'b00);
    chk_eq("rst_addr", o_vram_addr, '0);
    chk_eq("rst_din", o_vram_din, '0);
    chk_eq("rst_rvalid", o_rvalid, '0);
    model_reset();
    req = '0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t limit 1000000", $time);
    $fatal(1);
  end

  initial begin
    int nacc, run, first_run, guard, lost;
    for (int k = 0; k < NREQ; k++) begin
      addr[k] = '0;
      din[k]  = '0;
    end
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset_async();

    // Char writer writes three words at 0x000..0x002.
    req[REQ_CHAR] = 1'b1;
    we[REQ_CHAR]  = 1'b1;
    cycle();
    chk_eq("t1_gnt_pre", s_gnt, '0);
    for (int j = 0; j < 3; j++) begin
      addr[REQ_CHAR] = AW'(j);
      din[REQ_CHAR]  = DW'(8'h10 + j);
      cycle();
      chk_eq("t1_gnt", s_gnt, 3'b100);
      chk_eq("t1_ce_w", {s_ce, s_w}, 2'b11);
      chk_eq("t1_addr", s_addr, j);
      chk_eq("t1_din", s_din, 8'h10 + j);
    end
    req = '0; we = '0;
    cycle(); cycle();

    // Clear and char writer request together; handover with no gap.
    req = 3'b101;
    cycle();
    cycle();
    chk_eq("t2_first", s_gnt, 3'b001);
    req = 3'b100;
    cycle();
    chk_eq("t2_hold", s_gnt, 3'b001);
    cycle();
    chk_eq("t2_next", s_gnt, 3'b100);
    req = '0;
    cycle(); cycle();
    req = 3'b001;
    cycle(); cycle();
    req = '0;
    cycle(); cycle();
    req = 3'b101;
    cycle(); cycle();
`ifdef VRAM_ARB_RR_EN
    chk_eq("t2_rr", s_gnt, 3'b100);
`else
    chk_eq("t2_rr", s_gnt, 3'b001);
`endif
    req = '0;
    cycle(); cycle(); cycle();

    // Clear needs 10 accesses while the char writer waits: preempted after 4.
    nacc = 0; run = 0; first_run = -1; guard = 0;
    we = 3'b101;
    addr[REQ_CHAR] = 11'h200;
    req = 3'b101;
    while (nacc < 10 && guard < 100) begin
      addr[REQ_CLEAR] = AW'(11'h100 + nacc);
      cycle();
      if (s_gnt[REQ_CLEAR] && s_ce) begin
        chk_eq("t3_addr", s_addr, 11'h100 + nacc);
        nacc++;
        run++;
      end else if (run > 0 && first_run < 0) begin
        first_run = run;
      end
      guard++;
      if (nacc >= 10) req[REQ_CLEAR] = 1'b0;
    end
    chk_eq("t3_total", nacc, 10);
    chk_eq("t3_first_run", first_run, MAX_BURST);
    req = '0; we = '0;
    cycle(); cycle(); cycle();

    // Scroll reads 0x7FF; tagged return arrives RD_LAT cycles later after the grant moved.
    dout = 8'h41;
    addr[REQ_SCROLL] = 11'h7FF;
    req = 3'b010;
    cycle();
    req = 3'b011;
    cycle();
    chk_eq("t4_access", {s_gnt, s_ce, s_w}, {3'b010, 1'b1, 1'b0});
    chk_eq("t4_addr", s_addr, 11'h7FF);
    req = 3'b001;
    cycle();
    chk_eq("t4_rv_early", s_rv, '0);
    cycle();
    chk_eq("t4_rv", s_rv, 3'b010);
    chk_eq("t4_rdata", s_rd, 8'h41);
    chk_eq("t4_gnt_moved", s_gnt, 3'b001);
    req = '0;
    cycle(); cycle(); cycle();

    // Reset mid-burst with a read in flight discards the return.
    addr[REQ_SCROLL] = 11'h123;
    req = 3'b010;
    cycle(); cycle();
    reset_async();
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk_eq("t5_no_rv", s_rv, '0);
    end

    // Lone requester bursting well past MAX_BURST keeps the grant.
    lost = 0;
    req = 3'b001;
    for (int i = 0; i < 100; i++) begin
      addr[REQ_CLEAR] = AW'(i);
      we[REQ_CLEAR]   = 1'($urandom);
      cycle();
      if (i > 0 && s_gnt != 3'b001) lost++;
    end
    chk_eq("t6_lost", lost, 0);
    req = '0; we = '0;
    cycle(); cycle(); cycle();

    // Random traffic with sticky requests and occasional async resets.
    for (int i = 0; i < 2000; i++) begin
      for (int k = 0; k < NREQ; k++) begin
        if ($urandom_range(7) == 0) req[k] = ~req[k];
        we[k]   = 1'($urandom);
        addr[k] = AW'($urandom);
        din[k]  = DW'($urandom);
      end
      dout = DW'($urandom);
      if ($urandom_range(499) == 0) reset_async();
      else cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
